// File: rtl/lsb_multi_cdb.sv
// In-order load/store buffer with NUM_CDB-channel operand wakeup, one outstanding memory access.
// Optional LSB_MISALIGN_EN: misaligned head accesses retire locally with a misalign pulse instead of reaching memory.
module lsb_multi_cdb #(
    parameter int DEPTH_BITS = 3,
    parameter int DEPTH      = 1 << DEPTH_BITS,
    parameter int ROB_BITS   = 4,
    parameter int NUM_CDB    = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush,
    input  logic                        disp_valid,
    input  logic                        disp_is_store,
    input  logic [2:0]                  disp_funct3,
    input  logic [ROB_BITS-1:0]         disp_rob_id,
    input  logic [31:0]                 disp_imm,
    input  logic                        disp_rs1_rdy,
    input  logic [31:0]                 disp_rs1_val,
    input  logic [ROB_BITS-1:0]         disp_rs1_tag,
    input  logic                        disp_rs2_rdy,
    input  logic [31:0]                 disp_rs2_val,
    input  logic [ROB_BITS-1:0]         disp_rs2_tag,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_BITS-1:0] cdb_id,
    input  logic [NUM_CDB*32-1:0]       cdb_value,
    input  logic [ROB_BITS-1:0]         rob_head,
    output logic                        d_waiting,
    output logic                        d_wr,
    output logic [2:0]                  d_len,
    output logic [31:0]                 d_addr,
    output logic [31:0]                 d_value,
    input  logic                        mem_rdy,
    input  logic [31:0]                 mem_result,
    output logic                        finish_valid,
    output logic [ROB_BITS-1:0]         finish_id,
    output logic [31:0]                 finish_value,
`ifdef LSB_MISALIGN_EN
    output logic                        misalign,
`endif
    output logic                        full,
    output logic [DEPTH_BITS:0]         count
);

    localparam int CNT_W = DEPTH_BITS + 1;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

    state_t                state_reg;
    logic [DEPTH_BITS-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0]      count_reg;

    logic                valid_reg  [DEPTH];
    logic                store_reg  [DEPTH];
    logic [2:0]          funct3_reg [DEPTH];
    logic [ROB_BITS-1:0] dest_reg   [DEPTH];
    logic [31:0]         imm_reg    [DEPTH];
    logic                rj_reg     [DEPTH];
    logic                rk_reg     [DEPTH];
    logic [31:0]         vj_reg     [DEPTH];
    logic [31:0]         vk_reg     [DEPTH];
    logic [ROB_BITS-1:0] qj_reg     [DEPTH];
    logic [ROB_BITS-1:0] qk_reg     [DEPTH];
    logic [32:0]         wake_j     [DEPTH];
    logic [32:0]         wake_k     [DEPTH];

    // {hit, value}; iterating downwards lets the lowest matching channel win
    function automatic logic [32:0] cdb_lookup(input logic [ROB_BITS-1:0] tag);
        logic [32:0] r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_id[c*ROB_BITS +: ROB_BITS] == tag)
                r = {1'b1, cdb_value[c*32 +: 32]};
        end
        return r;
    endfunction

    // bit2 = signed/store, [1:0] = size; unknown funct3 encodings fall back to word
    function automatic logic [2:0] len_of(input logic st, input logic [2:0] f3);
        logic [1:0] sz;
        case (f3[1:0])
            2'b00:   sz = 2'b00;
            2'b01:   sz = 2'b01;
            default: sz = 2'b10;
        endcase
        return {st | ~f3[2], sz};
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] len, input logic [31:0] raw);
        logic [31:0] r;
        case (len[1:0])
            2'b00:   r = {{24{len[2] & raw[7]}}, raw[7:0]};
            2'b01:   r = {{16{len[2] & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
        assign wake_j[gi] = cdb_lookup(qj_reg[gi]);
        assign wake_k[gi] = cdb_lookup(qk_reg[gi]);
    end

    logic [32:0] disp_j, disp_k;
    assign disp_j = disp_rs1_rdy ? {1'b1, disp_rs1_val} : cdb_lookup(disp_rs1_tag);
    assign disp_k = !disp_is_store ? {1'b1, 32'h0} :
                    disp_rs2_rdy   ? {1'b1, disp_rs2_val} : cdb_lookup(disp_rs2_tag);

    logic        head_store, head_ready;
    logic [2:0]  head_len;
    logic [31:0] head_addr;
    assign head_store = store_reg[head_reg];
    assign head_len   = len_of(store_reg[head_reg], funct3_reg[head_reg]);
    assign head_addr  = vj_reg[head_reg] + imm_reg[head_reg];
    assign head_ready = valid_reg[head_reg] && rj_reg[head_reg] && rk_reg[head_reg] &&
                        (!head_store || dest_reg[head_reg] == rob_head);

    logic accept, mem_done, keep_head, local_retire, retire;
    assign full      = count_reg == CNT_W'(DEPTH);
    assign count     = count_reg;
    assign accept    = disp_valid && !full && !flush;
    assign mem_done  = state_reg == WAIT_MEM && mem_rdy;
    // an in-flight store has already been committed by the RoB, so flush must not drop it
    assign keep_head = flush && state_reg == WAIT_MEM && head_store;
`ifdef LSB_MISALIGN_EN
    logic head_misaligned;
    assign head_misaligned = (head_len[1:0] == 2'b01 && head_addr[0]) ||
                             (head_len[1:0] == 2'b10 && head_addr[1:0] != 2'b00);
    assign local_retire = state_reg == IDLE && head_ready && head_misaligned && !flush;
`else
    assign local_retire = 1'b0;
`endif
    assign retire = (mem_done && (!flush || head_store)) || local_retire;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) valid_reg[i] <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush)
                    valid_reg[i] <= keep_head && !retire && head_reg == DEPTH_BITS'(i);
                else if (retire && head_reg == DEPTH_BITS'(i))
                    valid_reg[i] <= 1'b0;
                if (!rj_reg[i] && wake_j[i][32]) begin
                    rj_reg[i] <= 1'b1;
                    vj_reg[i] <= wake_j[i][31:0];
                end
                if (!rk_reg[i] && wake_k[i][32]) begin
                    rk_reg[i] <= 1'b1;
                    vk_reg[i] <= wake_k[i][31:0];
                end
            end
            if (accept) begin
                valid_reg[tail_reg]  <= 1'b1;
                store_reg[tail_reg]  <= disp_is_store;
                funct3_reg[tail_reg] <= disp_funct3;
                dest_reg[tail_reg]   <= disp_rob_id;
                imm_reg[tail_reg]    <= disp_imm;
                rj_reg[tail_reg]     <= disp_j[32];
                vj_reg[tail_reg]     <= disp_j[31:0];
                qj_reg[tail_reg]     <= disp_rs1_tag;
                rk_reg[tail_reg]     <= disp_k[32];
                vk_reg[tail_reg]     <= disp_k[31:0];
                qk_reg[tail_reg]     <= disp_rs2_tag;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg    <= IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            d_waiting    <= 1'b0;
            d_wr         <= 1'b0;
            d_len        <= '0;
            d_addr       <= '0;
            d_value      <= '0;
            finish_valid <= 1'b0;
            finish_id    <= '0;
            finish_value <= '0;
`ifdef LSB_MISALIGN_EN
            misalign     <= 1'b0;
`endif
        end else if (rdy_in) begin
            finish_valid <= 1'b0;
`ifdef LSB_MISALIGN_EN
            misalign     <= 1'b0;
`endif
            if (flush) begin
                if (keep_head) begin
                    head_reg  <= retire ? head_reg + PTR_ONE : head_reg;
                    tail_reg  <= head_reg + PTR_ONE;
                    count_reg <= retire ? CNT_W'(0) : CNT_W'(1);
                end else begin
                    tail_reg  <= head_reg;
                    count_reg <= '0;
                end
            end else begin
                if (retire) head_reg <= head_reg + PTR_ONE;
                if (accept) tail_reg <= tail_reg + PTR_ONE;
                count_reg <= count_reg + CNT_W'(accept) - CNT_W'(retire);
            end

            case (state_reg)
                IDLE: begin
`ifdef LSB_MISALIGN_EN
                    if (local_retire) begin
                        finish_valid <= 1'b1;
                        finish_id    <= dest_reg[head_reg];
                        finish_value <= head_addr;
                        misalign     <= 1'b1;
                    end else
`endif
                    if (!flush && head_ready) begin
                        state_reg <= WAIT_MEM;
                        d_waiting <= 1'b1;
                        d_wr      <= head_store;
                        d_len     <= head_len;
                        d_addr    <= head_addr;
                        d_value   <= vk_reg[head_reg];
                    end
                end
                WAIT_MEM: begin
                    if (mem_rdy) begin
                        d_waiting <= 1'b0;
                        state_reg <= IDLE;
                        if (!flush || head_store) begin
                            finish_valid <= 1'b1;
                            finish_id    <= dest_reg[head_reg];
                            finish_value <= head_store ? 32'h0 : extend_load(head_len, mem_result);
                        end
                    end else if (flush && !head_store) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_rdy) begin
                        d_waiting <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsb_multi_cdb.sv
// Scoreboard bench for lsb_multi_cdb: stimulus pushes expected requests/finishes, a negedge monitor checks them.
module tb_lsb_multi_cdb;
    localparam int RB = 4;
    localparam int NC = 2;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, flush;
    logic disp_valid, disp_is_store;
    logic [2:0] disp_funct3;
    logic [RB-1:0] disp_rob_id, disp_rs1_tag, disp_rs2_tag, rob_head;
    logic [31:0] disp_imm, disp_rs1_val, disp_rs2_val;
    logic disp_rs1_rdy, disp_rs2_rdy;
    logic [NC-1:0] cdb_valid;
    logic [NC*RB-1:0] cdb_id;
    logic [NC*32-1:0] cdb_value;
    logic d_waiting, d_wr, mem_rdy, finish_valid, full;
    logic [2:0] d_len;
    logic [31:0] d_addr, d_value, mem_result, finish_value;
    logic [RB-1:0] finish_id;
    logic [3:0] count;
`ifdef LSB_MISALIGN_EN
    logic misalign;
`endif

    lsb_multi_cdb dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_funct3(disp_funct3),
        .disp_rob_id(disp_rob_id), .disp_imm(disp_imm),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_tag(disp_rs1_tag),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value), .rob_head(rob_head),
        .d_waiting(d_waiting), .d_wr(d_wr), .d_len(d_len), .d_addr(d_addr), .d_value(d_value),
        .mem_rdy(mem_rdy), .mem_result(mem_result),
        .finish_valid(finish_valid), .finish_id(finish_id), .finish_value(finish_value),
`ifdef LSB_MISALIGN_EN
        .misalign(misalign),
`endif
        .full(full), .count(count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        wr;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] value;
    } req_t;
    typedef struct packed {
        logic [RB-1:0] id;
        logic [31:0]   value;
        logic          mis;
    } fin_t;

    req_t req_q[$];
    fin_t fin_q[$];
    req_t mon_r;
    fin_t mon_f;
    logic dw_prev = 1'b0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic wr, input logic [2:0] len, input logic [31:0] addr, input logic [31:0] val);
        req_q.push_back(req_t'{wr, len, addr, val});
    endtask

    task automatic push_fin(input logic [RB-1:0] id, input logic [31:0] val, input logic mis);
        fin_q.push_back(fin_t'{id, val, mis});
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (d_waiting && !dw_prev) begin
                $display("request wr=%0b len=%03b addr=0x%08h value=0x%08h", d_wr, d_len, d_addr, d_value);
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr 0x%08h, required no request", d_addr);
                end else begin
                    mon_r = req_q.pop_front();
                    chk("req_wr", {31'b0, d_wr}, {31'b0, mon_r.wr});
                    chk("req_len", {29'b0, d_len}, {29'b0, mon_r.len});
                    chk("req_addr", d_addr, mon_r.addr);
                    chk("req_value", d_value, mon_r.value);
                end
            end
            if (finish_valid) begin
                $display("finish id=%0d value=0x%08h", finish_id, finish_value);
                if (fin_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_finish: got id %0d, required no finish", finish_id);
                end else begin
                    mon_f = fin_q.pop_front();
                    chk("fin_id", {28'b0, finish_id}, {28'b0, mon_f.id});
                    chk("fin_value", finish_value, mon_f.value);
`ifdef LSB_MISALIGN_EN
                    chk("fin_misalign", {31'b0, misalign}, {31'b0, mon_f.mis});
`endif
                end
            end
        end
        dw_prev = d_waiting;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic dispatch(input logic st, input logic [2:0] f3, input logic [RB-1:0] rob, input logic [31:0] imm,
                            input logic r1, input logic [31:0] v1, input logic [RB-1:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [RB-1:0] t2);
        disp_valid = 1'b1; disp_is_store = st; disp_funct3 = f3; disp_rob_id = rob; disp_imm = imm;
        disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
        disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic set_cdb(input int ch, input logic [RB-1:0] id, input logic [31:0] v);
        cdb_valid[ch] = 1'b1;
        cdb_id[ch*RB +: RB] = id;
        cdb_value[ch*32 +: 32] = v;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!d_waiting && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!d_waiting) begin
            errors++;
            $display("FAIL %s: d_waiting 0 after 20 cycles, required 1", name);
        end
    endtask

    task automatic mem_reply(input logic [31:0] data);
        mem_rdy = 1'b1;
        mem_result = data;
        tick();
        mem_rdy = 1'b0;
        mem_result = '0;
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [RB-1:0] rob,
                           input logic [31:0] base, input logic [31:0] imm, input logic [2:0] len,
                           input logic [31:0] raw, input logic [31:0] expv);
        push_req(1'b0, len, base + imm, 32'h0);
        push_fin(rob, expv, 1'b0);
        dispatch(1'b0, f3, rob, imm, 1'b1, base, '0, 1'b0, 32'h0, '0);
        wait_req(name);
        mem_reply(raw);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no summary by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
        disp_valid = 1'b0; disp_is_store = 1'b0; disp_funct3 = '0; disp_rob_id = '0; disp_imm = '0;
        disp_rs1_rdy = 1'b0; disp_rs1_val = '0; disp_rs1_tag = '0;
        disp_rs2_rdy = 1'b0; disp_rs2_val = '0; disp_rs2_tag = '0;
        cdb_valid = '0; cdb_id = '0; cdb_value = '0; rob_head = '0;
        mem_rdy = 1'b0; mem_result = '0;
        repeat (3) tick();
        chk("rst_d_waiting", {31'b0, d_waiting}, 0);
        chk("rst_d_wr", {31'b0, d_wr}, 0);
        chk("rst_d_len", {29'b0, d_len}, 0);
        chk("rst_d_addr", d_addr, 0);
        chk("rst_d_value", d_value, 0);
        chk("rst_finish_valid", {31'b0, finish_valid}, 0);
        chk("rst_finish_value", finish_value, 0);
        chk("rst_count", {28'b0, count}, 0);
        chk("rst_full", {31'b0, full}, 0);
        rst_in = 1'b1;

        // paused buffer ignores a dispatch
        rdy_in = 1'b0;
        dispatch(1'b0, 3'b010, 4'd1, 32'h0, 1'b1, 32'h10, '0, 1'b0, 32'h0, '0);
        chk("paused_count", {28'b0, count}, 0);
        rdy_in = 1'b1;
        tick();
        chk("paused_no_req", {31'b0, d_waiting}, 0);

        // lw, then width/sign variants
        push_req(1'b0, 3'b110, 32'h104, 32'h0);
        push_fin(4'd3, 32'h12345678, 1'b0);
        dispatch(1'b0, 3'b010, 4'd3, 32'h4, 1'b1, 32'h100, '0, 1'b0, 32'h0, '0);
        chk("lw_count", {28'b0, count}, 1);
        wait_req("lw_req");
        mem_reply(32'h12345678);
        tick();
        chk("lw_count_after", {28'b0, count}, 0);
        do_load("lb_req",  3'b000, 4'd1, 32'h200, 32'h0, 3'b100, 32'h80, 32'hFFFFFF80);
        do_load("lbu_req", 3'b100, 4'd2, 32'h201, 32'h0, 3'b000, 32'h80, 32'h00000080);
        do_load("lh_req",  3'b001, 4'd4, 32'h300, 32'h0, 3'b101, 32'h8001, 32'hFFFF8001);
        do_load("lhu_req", 3'b101, 4'd5, 32'h10, 32'hFFFFFFF8, 3'b001, 32'h8001, 32'h00008001);

        // store waits for rs2 wakeup on channel 1 and for rob_head
        rob_head = 4'd4;
        push_req(1'b1, 3'b110, 32'h408, 32'hAA);
        push_fin(4'd5, 32'h0, 1'b0);
        dispatch(1'b1, 3'b010, 4'd5, 32'h8, 1'b1, 32'h400, '0, 1'b0, 32'h0, 4'd2);
        repeat (3) tick();
        chk("sw_blocked_operand", {31'b0, d_waiting}, 0);
        set_cdb(0, 4'd9, 32'h55);
        set_cdb(1, 4'd2, 32'hAA);
        tick();
        cdb_valid = '0;
        tick();
        chk("sw_blocked_head", {31'b0, d_waiting}, 0);
        rob_head = 4'd5;
        wait_req("sw_req");
        mem_reply(32'hFFFFFFFF);
        tick();

        // duplicate match: channel 0 wins
        push_req(1'b0, 3'b110, 32'h500, 32'h0);
        push_fin(4'd6, 32'h77, 1'b0);
        dispatch(1'b0, 3'b010, 4'd6, 32'h0, 1'b0, 32'h0, 4'd6, 1'b0, 32'h0, '0);
        set_cdb(0, 4'd6, 32'h500);
        set_cdb(1, 4'd6, 32'h600);
        tick();
        cdb_valid = '0;
        wait_req("prio_req");
        mem_reply(32'h77);
        tick();

        // capture from broadcast in the dispatch cycle
        push_req(1'b0, 3'b110, 32'h710, 32'h0);
        push_fin(4'd7, 32'h1, 1'b0);
        set_cdb(1, 4'd7, 32'h700);
        dispatch(1'b0, 3'b010, 4'd7, 32'h10, 1'b0, 32'h0, 4'd7, 1'b0, 32'h0, '0);
        cdb_valid = '0;
        wait_req("dispcap_req");
        mem_reply(32'h1);
        tick();

        // fill with stores blocked on rob_head
        rob_head = 4'd0;
        for (int i = 0; i < 8; i++) begin
            push_req(1'b1, 3'b110, 32'h1000 + 32'(4 * i), 32'h100 + 32'(i));
            push_fin(RB'(8 + i), 32'h0, 1'b0);
            dispatch(1'b1, 3'b010, RB'(8 + i), 32'(4 * i), 1'b1, 32'h1000, '0, 1'b1, 32'h100 + 32'(i), '0);
        end
        chk("fill_count", {28'b0, count}, 8);
        chk("fill_full", {31'b0, full}, 1);
        dispatch(1'b0, 3'b010, 4'd15, 32'h0, 1'b1, 32'h9000, '0, 1'b0, 32'h0, '0);
        chk("full_ignored", {28'b0, count}, 8);
        rob_head = 4'd8;
        wait_req("fill_req0");
        mem_reply(32'h0);
        chk("retire_count", {28'b0, count}, 7);
        chk("retire_not_full", {31'b0, full}, 0);
        rob_head = 4'd9;
        wait_req("fill_req1");
        push_req(1'b0, 3'b110, 32'h5000, 32'h0);
        push_fin(4'd3, 32'h5555AAAA, 1'b0);
        mem_rdy = 1'b1;
        mem_result = 32'h0;
        dispatch(1'b0, 3'b010, 4'd3, 32'h0, 1'b1, 32'h5000, '0, 1'b0, 32'h0, '0);
        mem_rdy = 1'b0;
        chk("simul_count", {28'b0, count}, 7);
        for (int i = 2; i < 8; i++) begin
            rob_head = RB'(8 + i);
            wait_req("fill_req");
            mem_reply(32'h0);
        end
        wait_req("wrap_load_req");
        mem_reply(32'h5555AAAA);
        tick();
        chk("drain_fill_count", {28'b0, count}, 0);

        // flush with a store in flight keeps only that store
        rob_head = 4'd1;
        push_req(1'b1, 3'b110, 32'h2000, 32'h11);
        push_fin(4'd1, 32'h0, 1'b0);
        dispatch(1'b1, 3'b010, 4'd1, 32'h0, 1'b1, 32'h2000, '0, 1'b1, 32'h11, '0);
        dispatch(1'b0, 3'b010, 4'd2, 32'h0, 1'b1, 32'h2100, '0, 1'b0, 32'h0, '0);
        dispatch(1'b0, 3'b010, 4'd3, 32'h0, 1'b1, 32'h2200, '0, 1'b0, 32'h0, '0);
        wait_req("fst_req");
        flush = 1'b1;
        dispatch(1'b0, 3'b010, 4'd4, 32'h0, 1'b1, 32'h2300, '0, 1'b0, 32'h0, '0);
        flush = 1'b0;
        chk("fst_count", {28'b0, count}, 1);
        chk("fst_waiting", {31'b0, d_waiting}, 1);
        mem_reply(32'h1234);
        tick();
        chk("fst_count_after", {28'b0, count}, 0);
        repeat (3) tick();

        // flush with a load in flight drains without a finish
        push_req(1'b0, 3'b110, 32'h3000, 32'h0);
        dispatch(1'b0, 3'b010, 4'd6, 32'h0, 1'b1, 32'h3000, '0, 1'b0, 32'h0, '0);
        wait_req("fld_req");
        dispatch(1'b0, 3'b010, 4'd7, 32'h0, 1'b1, 32'h3400, '0, 1'b0, 32'h0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fld_waiting", {31'b0, d_waiting}, 1);
        chk("fld_count", {28'b0, count}, 0);
        push_req(1'b0, 3'b110, 32'h3100, 32'h0);
        push_fin(4'd8, 32'hCAFEBABE, 1'b0);
        dispatch(1'b0, 3'b010, 4'd8, 32'h0, 1'b1, 32'h3100, '0, 1'b0, 32'h0, '0);
        chk("drain_disp_count", {28'b0, count}, 1);
        tick();
        chk("drain_held", {31'b0, d_waiting}, 1);
        chk("drain_addr", d_addr, 32'h3000);
        mem_reply(32'hDEAD0000);
        chk("drain_release", {31'b0, d_waiting}, 0);
        wait_req("after_drain_req");
        mem_reply(32'hCAFEBABE);
        repeat (2) tick();
        chk("after_drain_count", {28'b0, count}, 0);

`ifdef LSB_MISALIGN_EN
        push_fin(4'd9, 32'h102, 1'b1);
        dispatch(1'b0, 3'b010, 4'd9, 32'h2, 1'b1, 32'h100, '0, 1'b0, 32'h0, '0);
        repeat (4) tick();
        chk("mis_no_req", {31'b0, d_waiting}, 0);
        chk("mis_count", {28'b0, count}, 0);
`endif

        repeat (5) tick();
        chk("req_q_empty", req_q.size(), 0);
        chk("fin_q_empty", fin_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
